// File: rtl/sprite_blit_pkg.sv
// Shared types and helpers for the sprite blitter: state encoding, default screen
// geometry and a field extractor for the packed per-channel configuration buses.
package sprite_blit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_SCAN   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } blit_state_e;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

  localparam int BUS_MAX   = 512;
  localparam int FIELD_MAX = 32;

  // Returns field idx of width w from a packed bus with field 0 at the LSBs.
  function automatic logic [FIELD_MAX-1:0] bus_field(input logic [BUS_MAX-1:0] bus,
                                                     input int idx, input int w);
    return FIELD_MAX'(bus >> (idx * w)) & ((FIELD_MAX'(1) << w) - FIELD_MAX'(1));
  endfunction

endpackage

// File: rtl/sprite_scan_counter.sv
// Column/row raster counter with runtime last-index limits; 'last' flags the
// final pixel of the rectangle.
module sprite_scan_counter #(
  parameter int X_W = 8,
  parameter int Y_W = 7
) (
  input  logic           CLOCK_50,
  input  logic           Resetn,
  input  logic           clr,
  input  logic           en,
  input  logic [X_W-1:0] wl,
  input  logic [Y_W-1:0] hl,
  output logic [X_W-1:0] col,
  output logic [Y_W-1:0] row,
  output logic           last
);

  assign last = (col == wl) && (row == hl);

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn || clr) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (col == wl) begin
        col <= '0;
        row <= row + Y_W'(1);
      end else begin
        col <= col + X_W'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Multi-channel sprite plotter for the 160x120 VGA adapter path.
// Optional colour-key transparency is enabled by defining SPRITE_BLIT_TRANSPARENT_EN.
//
// state  | meaning
// IDLE   | waiting for start
// SELECT | pick lowest pending channel, clear counters (or finish if none left)
// SCAN   | one ROM address per cycle across the channel rectangle
// DRAIN  | two cycles to flush the ROM/tag pipeline
// DONE   | one-cycle end-of-frame pulse
module sprite_blitter
  import sprite_blit_pkg::*;
#(
  parameter int NUM_CH   = 9,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOR_W  = 3,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter logic [COLOR_W-1:0] TRANSP_COLOR = '0
) (
  input  logic                      CLOCK_50,
  input  logic                      Resetn,
  input  logic                      start,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic [NUM_CH*X_W-1:0]     ch_x,
  input  logic [NUM_CH*Y_W-1:0]     ch_y,
  input  logic [NUM_CH*X_W-1:0]     ch_wl,
  input  logic [NUM_CH*Y_W-1:0]     ch_hl,
  output logic [$clog2(NUM_CH)-1:0] rom_ch,
  output logic [X_W-1:0]            rom_col,
  output logic [Y_W-1:0]            rom_row,
  input  logic [COLOR_W-1:0]        rom_colour,
  output logic                      plot,
  output logic [X_W-1:0]            x,
  output logic [Y_W-1:0]            y,
  output logic [COLOR_W-1:0]        colour,
  output logic                      busy,
  output logic                      done
);

  localparam int CH_W = $clog2(NUM_CH);

  localparam logic [2:0] IDLE   = ST_IDLE;
  localparam logic [2:0] SELECT = ST_SELECT;
  localparam logic [2:0] SCAN   = ST_SCAN;
  localparam logic [2:0] DRAIN  = ST_DRAIN;
  localparam logic [2:0] DONE   = ST_DONE;

`ifdef SPRITE_BLIT_TRANSPARENT_EN
  localparam bit TRANSP_EN = 1'b1;
`else
  localparam bit TRANSP_EN = 1'b0;
`endif

  logic [2:0]            state;
  logic [NUM_CH-1:0]     pend;
  logic [NUM_CH*X_W-1:0] x_q, wl_q;
  logic [NUM_CH*Y_W-1:0] y_q, hl_q;
  logic [X_W-1:0]        ox, wl;
  logic [Y_W-1:0]        oy, hl;
  logic                  drain_cnt;
  logic [CH_W-1:0]       next_ch;
  logic [X_W-1:0]        col;
  logic [Y_W-1:0]        row;
  logic                  last;
  logic [X_W:0]          x_sum;
  logic [Y_W:0]          y_sum;
  logic                  clip;
  logic                  v1;
  logic [X_W-1:0]        x1;
  logic [Y_W-1:0]        y1;
  logic                  key_hit;

  always_comb begin
    next_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend[i]) next_ch = CH_W'(i);
    end
  end

  sprite_scan_counter #(.X_W(X_W), .Y_W(Y_W)) u_scan (
    .CLOCK_50 (CLOCK_50),
    .Resetn   (Resetn),
    .clr      (state == SELECT),
    .en       (state == SCAN),
    .wl       (wl),
    .hl       (hl),
    .col      (col),
    .row      (row),
    .last     (last)
  );

  assign rom_col = col;
  assign rom_row = row;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      state     <= IDLE;
      pend      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      wl_q      <= '0;
      hl_q      <= '0;
      ox        <= '0;
      oy        <= '0;
      wl        <= '0;
      hl        <= '0;
      rom_ch    <= '0;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pend  <= ch_en;
            x_q   <= ch_x;
            y_q   <= ch_y;
            wl_q  <= ch_wl;
            hl_q  <= ch_hl;
            state <= SELECT;
          end
        end
        SELECT: begin
          if (|pend) begin
            pend[next_ch] <= 1'b0;
            rom_ch <= next_ch;
            ox     <= X_W'(bus_field(BUS_MAX'(x_q),  int'(next_ch), X_W));
            oy     <= Y_W'(bus_field(BUS_MAX'(y_q),  int'(next_ch), Y_W));
            wl     <= X_W'(bus_field(BUS_MAX'(wl_q), int'(next_ch), X_W));
            hl     <= Y_W'(bus_field(BUS_MAX'(hl_q), int'(next_ch), Y_W));
            state  <= SCAN;
          end else begin
            drain_cnt <= 1'b1;
            state     <= DRAIN;
          end
        end
        SCAN: begin
          if (last) state <= SELECT;
        end
        DRAIN: begin
          if (drain_cnt == 1'b0) state <= DONE;
          else drain_cnt <= 1'b0;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Coordinates are formed one bit wider so off-screen pixels clip instead of wrapping.
  assign x_sum   = {1'b0, ox} + {1'b0, col};
  assign y_sum   = {1'b0, oy} + {1'b0, row};
  assign clip    = (x_sum >= (X_W+1)'(SCREEN_W)) || (y_sum >= (Y_W+1)'(SCREEN_H));
  assign key_hit = TRANSP_EN && (rom_colour == TRANSP_COLOR);

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      v1     <= 1'b0;
      x1     <= '0;
      y1     <= '0;
      plot   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
    end else begin
      v1 <= (state == SCAN) && !clip;
      if (state == SCAN) begin
        x1 <= x_sum[X_W-1:0];
        y1 <= y_sum[Y_W-1:0];
      end
      plot <= v1 && !key_hit;
      if (v1) begin
        x      <= x1;
        y      <= y1;
        colour <= rom_colour;
      end
    end
  end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Parametrised multi-channel sprite plotter for the 160x120 VGA adapter path. On a `start` pulse it walks every enabled channel in ascending index order and rasters each sprite's rectangle row-major, fetching pixels from an external synchronous sprite ROM. It drives the adapter's `plot`/`x`/`y`/`colour` inputs. It replaces the per-sprite column/row counter pairs and the downstream case-mux with one sequencer plus per-channel origin, size and enable.

## Interface
Parameters:
- `NUM_CH`, 9: number of sprite channels.
- `X_W`, 8: screen x width.
- `Y_W`, 7: screen y width.
- `COLOR_W`, 3: colour width.
- `SCREEN_W`, 160: pixels with x ≥ this are clipped.
- `SCREEN_H`, 120: pixels with y ≥ this are clipped.
- `TRANSP_COLOR`, 3'b000: transparency key, used only with `SPRITE_BLIT_TRANSPARENT_EN`.

Ports:
- `CLOCK_50`  in  1  clock.
- `Resetn`  in  1  reset; synchronous, active-low.
- `start`  in  1  frame request; accepted only in IDLE.
- `ch_en`  in  NUM_CH  per-channel enable.
- `ch_x`  in  NUM_CH*X_W  per-channel origin x, packed with ch0 at the LSBs.
- `ch_y`  in  NUM_CH*Y_W  per-channel origin y, packed.
- `ch_wl`  in  NUM_CH*X_W  per-channel last column index (width−1), packed.
- `ch_hl`  in  NUM_CH*Y_W  per-channel last row index (height−1), packed.
- `rom_ch`  out  $clog2(NUM_CH)  ROM channel select.
- `rom_col`  out  X_W  ROM column address.
- `rom_row`  out  Y_W  ROM row address.
- `rom_colour`  in  COLOR_W  ROM data, valid 1 cycle after the address.
- `plot`  out  1  adapter write strobe.
- `x`  out  X_W  pixel x.
- `y`  out  Y_W  pixel y.
- `colour`  out  COLOR_W  pixel colour.
- `busy`  out  1  high from the cycle after `start` is accepted until the cycle DONE is exited.
- `done`  out  1  single-cycle end-of-frame pulse.

## Operation
- States:
  - IDLE: if `start`, go to SELECT.
  - SELECT: if the pending mask is nonzero, go to SCAN; otherwise go to DRAIN.
  - SCAN: on the last pixel of the channel, go to SELECT.
  - DRAIN: 2 cycles, then DONE.
  - DONE: 1 cycle, then IDLE.
- On `start` acceptance, latch `ch_en` into the pending mask and latch all of `ch_x`/`ch_y`/`ch_wl`/`ch_hl`. Input changes mid-frame have no effect.
- SELECT uses a priority encoder to pick the lowest set pending bit, loads it into `rom_ch`, clears that bit, and zeroes `col`/`row`. It takes one cycle per channel, whatever the gaps in the mask.
- SCAN presents one address per cycle. `col` increments. When `col == wl`, `col` wraps to 0 and `row` increments. When `col == wl` and `row == hl`, this is the channel's last pixel.
- `wl = 0` or `hl = 0` means a 1-pixel-wide or 1-pixel-tall sprite. A 0/0 sprite is exactly 1 pixel.
- Pixel address: x = origin_x + col and y = origin_y + row, computed at X_W+1 and Y_W+1 bits with no wrap.
- A pixel is clipped (its `plot` is 0) if x ≥ SCREEN_W or y ≥ SCREEN_H.
- Higher channels are drawn later, so they overdraw lower ones.
- `start` seen in any state other than IDLE is ignored. It is not queued.
- Reset at any point returns the FSM to IDLE and clears the mask. Outputs return to their reset values on the next edge.
- Reset values: `plot`=0, `x`=0, `y`=0, `colour`=0, `rom_ch`=0, `rom_col`=0, `rom_row`=0, `busy`=0, `done`=0.

## Timing
- Address is registered in cycle t, `rom_colour` is valid in t+1, and `plot`/`x`/`y`/`colour` are registered outputs valid in t+2. Pixel latency is 2 cycles.
- A valid pixel/coordinate tag pipeline (2 stages) runs alongside the ROM. DRAIN flushes it, so the last `plot` always precedes `done`.
- Throughput is 1 pixel per clock inside a channel, plus 1 SELECT bubble per channel.
- Frame length from `start` edge k: SELECT at k+1, then for each enabled channel 1 SELECT cycle plus (wl+1)(hl+1) SCAN cycles, then 2 DRAIN cycles, then `done` for 1 cycle.
- All channels disabled: `done` is high at k+4 and `busy` is low at k+5.
- `plot` is never high while in IDLE or DONE.

## Configuration
- `SPRITE_BLIT_TRANSPARENT_EN` defined: a pixel with `rom_colour == TRANSP_COLOR` has `plot`=0. x/y still advance.
- Not defined: every unclipped pixel plots, and `TRANSP_COLOR` is unused.

## Structure
- Package `sprite_blit_pkg`: state enum (IDLE, SELECT, SCAN, DRAIN, DONE), default `SCREEN_W`/`SCREEN_H` constants, and a function to unpack a field from a packed channel bus.
- Sub-module `sprite_scan_counter`: the col/row pair with runtime limits, enable, clear, and a `last` flag. Instantiated once.

## Test plan
- Single channel: ch0 at (10,20), wl=3, hl=1, `rom_colour` = col+row → exactly 8 plots, at (10..13,20) then (10..13,21), with correct colours; `done` 2 cycles after the last plot.
- ch_en=9'b100000101: channels drawn in order 0, 2, 8; `rom_ch` sequence matches; ch8 pixels overdraw overlapping ch0 pixels.
- Clipping: ch0 at (158,118), wl=hl=3 → only (158,118), (159,118), (158,119), (159,119) plot; 16 SCAN cycles still elapse.
- All disabled: `start` at edge k → `done`=1 at k+4, no `plot` at any point.
- `start` re-pulsed mid-frame and `ch_x` changed mid-frame → no restart, positions unchanged. Reset mid-SCAN → next cycle all outputs 0 and FSM in IDLE.
- With `SPRITE_BLIT_TRANSPARENT_EN` and ROM returning 0 on even columns → only odd columns plot. Without the macro, all columns plot.
